// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encodings, op width and condition-flag bit positions.
// Imported by alu_unit and by the EX stage that drives it.
package alu_pkg;

    localparam int ALUOP_L = 5;

    localparam logic [ALUOP_L-1:0] ALU_ADD   = 5'd0;
    localparam logic [ALUOP_L-1:0] ALU_ADDU  = 5'd1;
    localparam logic [ALUOP_L-1:0] ALU_SUB   = 5'd2;
    localparam logic [ALUOP_L-1:0] ALU_SUBU  = 5'd3;
    localparam logic [ALUOP_L-1:0] ALU_AND   = 5'd4;
    localparam logic [ALUOP_L-1:0] ALU_OR    = 5'd5;
    localparam logic [ALUOP_L-1:0] ALU_XOR   = 5'd6;
    localparam logic [ALUOP_L-1:0] ALU_NOR   = 5'd7;
    localparam logic [ALUOP_L-1:0] ALU_SLT   = 5'd8;
    localparam logic [ALUOP_L-1:0] ALU_SLTU  = 5'd9;
    localparam logic [ALUOP_L-1:0] ALU_SLL   = 5'd10;
    localparam logic [ALUOP_L-1:0] ALU_SRL   = 5'd11;
    localparam logic [ALUOP_L-1:0] ALU_SRA   = 5'd12;
    localparam logic [ALUOP_L-1:0] ALU_LUI   = 5'd13;
    localparam logic [ALUOP_L-1:0] ALU_ADDC  = 5'd14;
    localparam logic [ALUOP_L-1:0] ALU_SUBB  = 5'd15;
    localparam logic [ALUOP_L-1:0] ALU_PASSA = 5'd16;
    localparam logic [ALUOP_L-1:0] ALU_PASSB = 5'd17;
    localparam logic [ALUOP_L-1:0] ALU_MUL   = 5'd18;
    localparam logic [ALUOP_L-1:0] ALU_EQ    = 5'd19;
    localparam logic [ALUOP_L-1:0] ALU_NE    = 5'd20;

    // Bit positions inside the registered {V, C, Z} flag word.
    localparam int ST_Z = 0;
    localparam int ST_C = 1;
    localparam int ST_V = 2;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for alu_unit: produces SLL, SRL and SRA of a_i
// by shamt_i in parallel; the parent selects the one it needs.
module alu_shifter #(
    parameter int W    = 32,
    parameter int SH_W = $clog2(W)
) (
    input  logic [W-1:0]    a_i,
    input  logic [SH_W-1:0] shamt_i,
    output logic [W-1:0]    sll_o,
    output logic [W-1:0]    srl_o,
    output logic [W-1:0]    sra_o
);

    assign sll_o = a_i << shamt_i;
    assign srl_o = a_i >> shamt_i;
    assign sra_o = $signed(a_i) >>> shamt_i;

endmodule

// File: rtl/alu_unit.sv
// EX-stage integer ALU: combinational result, {V,C,Z} flags registered one clock later.
// Optional feature macro ALU_MUL_EN enables the signed multiply on op 18.
module alu_unit #(
    parameter int REG_SZ  = 32,
    parameter int ALUOP_L = alu_pkg::ALUOP_L
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [REG_SZ-1:0] a,
    input  logic signed [REG_SZ-1:0] b,
    input  logic                     c,
    input  logic [ALUOP_L-1:0]       op,
    output logic signed [REG_SZ-1:0] ans,
    output logic [2:0]               st
);
    import alu_pkg::*;

    localparam int SH_W = $clog2(REG_SZ);

    logic [REG_SZ-1:0] ans_d;
    logic [2:0]        st_d;
    logic [2:0]        st_q;
    logic [REG_SZ:0]   sum;
    logic [REG_SZ:0]   dif;
    logic              cin;
    logic              bin;
    logic [REG_SZ-1:0] sll_r;
    logic [REG_SZ-1:0] srl_r;
    logic [REG_SZ-1:0] sra_r;
    logic              sa;
    logic              sb;

    alu_shifter #(
        .W    (REG_SZ),
        .SH_W (SH_W)
    ) u_shifter (
        .a_i     (a),
        .shamt_i (b[SH_W-1:0]),
        .sll_o   (sll_r),
        .srl_o   (srl_r),
        .sra_o   (sra_r)
    );

`ifdef ALU_MUL_EN
    logic signed [REG_SZ-1:0] prod;
    assign prod = a * b;
`endif

    // One extra bit on the adder and subtractor gives carry-out / borrow directly.
    assign cin = (op == ALU_ADDC) ? c : 1'b0;
    assign bin = (op == ALU_SUBB) ? c : 1'b0;
    assign sum = {1'b0, a} + {1'b0, b} + {{REG_SZ{1'b0}}, cin};
    assign dif = {1'b0, a} - {1'b0, b} - {{REG_SZ{1'b0}}, bin};
    assign sa  = a[REG_SZ-1];
    assign sb  = b[REG_SZ-1];

    always_comb begin
        ans_d = '0;
        unique case (op)
            ALU_ADD, ALU_ADDU, ALU_ADDC: ans_d = sum[REG_SZ-1:0];
            ALU_SUB, ALU_SUBU, ALU_SUBB: ans_d = dif[REG_SZ-1:0];
            ALU_AND:   ans_d = a & b;
            ALU_OR:    ans_d = a | b;
            ALU_XOR:   ans_d = a ^ b;
            ALU_NOR:   ans_d = ~(a | b);
            ALU_SLT:   ans_d = {{(REG_SZ-1){1'b0}}, (a < b)};
            ALU_SLTU:  ans_d = {{(REG_SZ-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            ALU_SLL:   ans_d = sll_r;
            ALU_SRL:   ans_d = srl_r;
            ALU_SRA:   ans_d = sra_r;
            ALU_LUI:   ans_d = {b[15:0], {(REG_SZ-16){1'b0}}};
            ALU_PASSA: ans_d = a;
            ALU_PASSB: ans_d = b;
`ifdef ALU_MUL_EN
            ALU_MUL:   ans_d = prod;
`endif
            ALU_EQ:    ans_d = {{(REG_SZ-1){1'b0}}, (a == b)};
            ALU_NE:    ans_d = {{(REG_SZ-1){1'b0}}, (a != b)};
            default:   ans_d = '0;
        endcase
    end

    always_comb begin
        st_d       = '0;
        st_d[ST_Z] = (ans_d == '0);
        unique case (op)
            ALU_ADD, ALU_ADDC: begin
                st_d[ST_C] = sum[REG_SZ];
                st_d[ST_V] = (sa == sb) && (sum[REG_SZ-1] != sa);
            end
            ALU_ADDU: st_d[ST_C] = sum[REG_SZ];
            ALU_SUB, ALU_SUBB: begin
                st_d[ST_C] = dif[REG_SZ];
                st_d[ST_V] = (sa != sb) && (dif[REG_SZ-1] != sa);
            end
            ALU_SUBU: st_d[ST_C] = dif[REG_SZ];
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= '0;
        else     st_q <= st_d;
    end

    assign ans = ans_d;
    assign st  = st_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: table of {op, a, b, c, ans, st} plus
// hand sequences for asynchronous reset and flag latency.
module tb_alu_unit;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] exp_ans;
        logic [2:0]  exp_st;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic               c;
    logic [4:0]         op;
    logic signed [31:0] ans;
    logic [2:0]         st;

    int n_app = 0;
    int n_err = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    alu_unit dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .op  (op),
        .ans (ans),
        .st  (st)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [4:0] o, input logic [31:0] va,
                       input logic [31:0] vb, input logic vc, input logic [31:0] ea,
                       input logic [2:0] es);
        vec_t v;
        v.name = nm; v.op = o; v.a = va; v.b = vb; v.c = vc;
        v.exp_ans = ea; v.exp_st = es;
        vq.push_back(v);
    endtask

    initial begin
        //    name         op   a             b             c     ans           {V,C,Z}
        add("add_ovf",   0,  32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 3'b100);
        add("addu_novf", 1,  32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 3'b000);
        add("addu_cz",   1,  32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        3'b011);
        add("add_ign_c", 0,  32'h1,        32'h1,        1'b1, 32'h2,        3'b000);
        add("sub_borr",  2,  32'h3,        32'h5,        1'b0, 32'hFFFFFFFE, 3'b010);
        add("sub_zero",  2,  32'h5,        32'h5,        1'b0, 32'h0,        3'b001);
        add("sub_ovf",   2,  32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 3'b100);
        add("subu_borr", 3,  32'h3,        32'h5,        1'b0, 32'hFFFFFFFE, 3'b010);
        add("addc",      14, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        3'b011);
        add("subb",      15, 32'd10,       32'd3,        1'b1, 32'd6,        3'b000);
        add("and",       4,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 3'b000);
        add("or",        5,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0, 3'b000);
        add("xor",       6,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 3'b000);
        add("nor",       7,  32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 3'b000);
        add("slt",       8,  32'hFFFFFFFF, 32'h1,        1'b0, 32'h1,        3'b000);
        add("sltu",      9,  32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        3'b001);
        add("sll31",     10, 32'h1,        32'd31,       1'b0, 32'h80000000, 3'b000);
        add("sll_sh0",   10, 32'h1234,     32'd32,       1'b0, 32'h1234,     3'b000);
        add("srl",       11, 32'h80000000, 32'd35,       1'b0, 32'h10000000, 3'b000);
        add("sra",       12, 32'h80000000, 32'd35,       1'b0, 32'hF0000000, 3'b000);
        add("lui",       13, 32'hDEADBEEF, 32'h1234,     1'b0, 32'h12340000, 3'b000);
        add("passa",     16, 32'd5,        32'd9,        1'b0, 32'd5,        3'b000);
        add("passb",     17, 32'd5,        32'd9,        1'b0, 32'd9,        3'b000);
        add("eq",        19, 32'd7,        32'd7,        1'b0, 32'd1,        3'b000);
        add("ne",        20, 32'd7,        32'd7,        1'b0, 32'd0,        3'b001);
        add("unsup25",   25, 32'h1234,     32'h5678,     1'b1, 32'h0,        3'b001);
`ifdef ALU_MUL_EN
        add("mul",       18, 32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFEB, 3'b000);
`else
        add("mul_off",   18, 32'hFFFFFFFD, 32'd7,        1'b0, 32'h0,        3'b001);
`endif

        rst = 1'b1; a = '0; b = '0; c = 1'b0; op = 5'd4;
        #1;
        chk("reset_st", {29'b0, st}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            a = vq[i].a; b = vq[i].b; c = vq[i].c; op = vq[i].op;
            #1;
            chk({vq[i].name, "_ans"}, ans, vq[i].exp_ans);
            @(posedge clk);
            #1;
            chk({vq[i].name, "_st"}, {29'b0, st}, {29'b0, vq[i].exp_st});
        end

        // Flags lag one edge: after switching inputs, st still holds the old flags.
        @(negedge clk);
        a = 32'h7FFFFFFF; b = 32'h1; c = 1'b0; op = 5'd0;
        @(posedge clk); #1;
        chk("ovf_capt", {29'b0, st}, 32'h4);
        @(negedge clk);
        a = 32'd5; b = 32'd5; op = 5'd2;
        #1;
        chk("lag_hold", {29'b0, st}, 32'h4);

        // Asynchronous reset mid-cycle clears st with no clock edge; ans untouched.
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", {29'b0, st}, 32'h0);
        chk("rst_ans", ans, 32'h0);
        a = 32'h7FFFFFFF; b = 32'h1; op = 5'd0;
        #1;
        chk("rst_ans_comb", ans, 32'h80000000);
        @(posedge clk); #1;
        chk("rst_hold", {29'b0, st}, 32'h0);
        @(negedge clk);
        a = 32'h3; b = 32'h5; op = 5'd2;
        rst = 1'b0;
        #1;
        chk("post_rst", {29'b0, st}, 32'h0);
        @(posedge clk); #1;
        chk("first_capt", {29'b0, st}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
        $finish;
    end

endmodule
